// File: rtl/iram_fifo_pkg.sv
// Shared definitions for the BRAM-backed valid/ready FIFO controller.
//  - state_t     : controller FSM states (RUN, FLUSH)
//  - IRAM_DW/AW  : default data and address widths of the BRAM
//  - occ_width() : width of occupancy counters (AW+1, counts 0..DEPTH+2)
package iram_fifo_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam int IRAM_DW = 85;
    localparam int IRAM_AW = 6;

    function automatic int occ_width(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/iram_fifo_obuf.sv
// Two-entry registered output buffer that sits behind the BRAM read port.
// Ports:
//  clk, reset   : clock, synchronous active-high reset
//  clear        : synchronous discard of both entries
//  push         : load push_data (caller guarantees a free slot, counting a same-cycle pop)
//  push_data    : word arriving from the BRAM read port
//  pop          : remove the head entry (caller guarantees cnt > 0)
//  cnt          : number of valid entries (0..2)
//  head         : oldest entry, driven straight from a register
module iram_fifo_obuf
    import iram_fifo_pkg::*;
#(
    parameter int DW = IRAM_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [1:0]    cnt,
    output logic [DW-1:0] head
);

    logic [DW-1:0] tail;

    // Shift-register organisation: head is always entry 0, so the
    // consumer-facing data never passes through a read mux.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt  <= '0;
            head <= '0;
            tail <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) head <= push_data;
                    else             tail <= push_data;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        head <= push_data;
                    end else begin
                        head <= tail;
                        tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/iram_fifo_ctl.sv
// Sequencing controller that turns an external 1R1W single-clock BRAM
// (1-cycle registered read) into a valid/ready FIFO with registered rd_data.
// Ports:
//  clk, reset            : clock, synchronous active-high reset
//  flush                 : synchronous discard of all contents
//  wr_valid/wr_ready/wr_data : producer side
//  rd_valid/rd_ready/rd_data : consumer side (rd_data registered)
//  count                 : total occupancy (BRAM + in-flight read + output buffer)
//  almost_full           : count >= AFULL_THRESH
//  ram_ena/wea/addra/dia : BRAM write port
//  ram_enb/addrb/dob     : BRAM read port (dob valid the cycle after enb)
// Optional feature (macro IRAM_FIFO_HWM_EN):
//  hwm                   : highest count seen since reset or flush
//  ovf_err               : sticky, write attempted while full with no drain
module iram_fifo_ctl
    import iram_fifo_pkg::*;
#(
    parameter int DW           = IRAM_DW,
    parameter int AW           = IRAM_AW,
    parameter int DEPTH        = 2 ** AW,
    parameter int AFULL_THRESH = 56
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic [AW:0]   count,
    output logic          almost_full,
    output logic          ram_ena,
    output logic          ram_wea,
    output logic [AW-1:0] ram_addra,
    output logic [DW-1:0] ram_dia,
    output logic          ram_enb,
    output logic [AW-1:0] ram_addrb,
    input  logic [DW-1:0] ram_dob
`ifdef IRAM_FIFO_HWM_EN
    ,
    output logic [AW:0]   hwm,
    output logic          ovf_err
`endif
);

    localparam int CW = occ_width(AW);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] ram_cnt;
    logic          inflight;
    logic [1:0]    obuf_cnt;
    logic          accept, issue, pop;

    assign rd_valid = (obuf_cnt != 2'd0);
    assign pop      = rd_valid && rd_ready;

    always_comb begin
        state_d  = state_q;
        wr_ready = 1'b0;
        accept   = 1'b0;
        issue    = 1'b0;
        case (state_q)
            RUN: begin
                wr_ready = (ram_cnt < DEPTH_C);
                // A write offered together with flush is discarded.
                accept   = wr_valid && wr_ready && !flush;
                // Issue only if the word will have a buffer slot when it lands;
                // a same-cycle pop frees one, keeping 1 word/cycle streaming.
                issue    = (ram_cnt != '0) && !flush &&
                           (({1'b0, obuf_cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
                if (flush) state_d = FLUSH;
            end
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                // Clearing inflight drops any read still returning from the BRAM.
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                ram_cnt  <= '0;
                inflight <= 1'b0;
            end else begin
                if (accept) wr_ptr <= wr_ptr + 1'b1;
                if (issue)  rd_ptr <= rd_ptr + 1'b1;
                inflight <= issue;
                if (accept && !issue)      ram_cnt <= ram_cnt + 1'b1;
                else if (!accept && issue) ram_cnt <= ram_cnt - 1'b1;
            end
        end
    end

    iram_fifo_obuf #(.DW(DW)) u_obuf (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (inflight),
        .push_data (ram_dob),
        .pop       (pop),
        .cnt       (obuf_cnt),
        .head      (rd_data)
    );

    assign count       = ram_cnt + CW'(inflight) + CW'(obuf_cnt);
    assign almost_full = (count >= AFULL_C);

    assign ram_ena   = accept;
    assign ram_wea   = accept;
    assign ram_addra = wr_ptr;
    assign ram_dia   = accept ? wr_data : '0;
    assign ram_enb   = issue;
    assign ram_addrb = rd_ptr;

`ifdef IRAM_FIFO_HWM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hwm     <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (flush)            hwm <= '0;
            else if (count > hwm) hwm <= count;
            if (state_q == RUN && wr_valid && !wr_ready && ram_cnt == DEPTH_C && !pop && !issue)
                ovf_err <= 1'b1;
        end
    end
`endif

endmodule
